// File: rtl/izh_neuron_scheduler_pkg.sv
// Shared constants, encodings and the saturating adder for the Izhikevich
// neuron scheduler and its current accumulator.
package izh_pkg;

  localparam int unsigned W    = 17;
  localparam int          FRAC = 8;

  localparam logic [W-1:0] V_RESET = W'(-(65 <<< FRAC));
  localparam logic [W-1:0] SAT_MAX = 17'h0FFFF;
  localparam logic [W-1:0] SAT_MIN = 17'h10000;

  typedef enum logic [2:0] {
    CFG_A = 3'd0,
    CFG_B = 3'd1,
    CFG_C = 3'd2,
    CFG_D = 3'd3,
    CFG_V = 3'd4,
    CFG_U = 3'd5
  } cfg_sel_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_SPIKE,
    S_NEXT,
    S_DONE
  } state_e;

  // Signed W-bit add clamped to [SAT_MIN, SAT_MAX].
  function automatic logic [W-1:0] sat_add(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] s;
    s = {x[W-1], x} + {y[W-1], y};
    if (s[W] != s[W-1]) return s[W] ? SAT_MIN : SAT_MAX;
    return s[W-1:0];
  endfunction

endpackage

// File: rtl/izh_current_accum.sv
// Per-neuron input-current accumulators: a clear and a saturating add may
// hit the same entry in one cycle; the clear is applied first.
module izh_current_accum
  import izh_pkg::*;
#(
  parameter int unsigned N_NEURONS = 16,
  parameter int unsigned IDX_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_en_i,
  input  logic [IDX_W-1:0] clr_idx_i,
  input  logic             add_en_i,
  input  logic [IDX_W-1:0] add_idx_i,
  input  logic [W-1:0]     add_data_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [W-1:0]     rd_data_o
);

  logic [W-1:0] cur_q [N_NEURONS];
  logic [W-1:0] cur_d [N_NEURONS];

  always_comb begin
    for (int unsigned n = 0; n < N_NEURONS; n++) begin
      cur_d[n] = cur_q[n];
      if (clr_en_i && clr_idx_i == IDX_W'(n)) cur_d[n] = '0;
      if (add_en_i && add_idx_i == IDX_W'(n)) cur_d[n] = sat_add(cur_d[n], add_data_i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned n = 0; n < N_NEURONS; n++) cur_q[n] <= '0;
    end else begin
      cur_q <= cur_d;
    end
  end

  assign rd_data_o = cur_q[rd_idx_i];

endmodule

// File: rtl/izh_neuron_scheduler.sv
// Timestep sequencer for the Izhikevich datapath: walks every neuron, feeds
// its parameters/state/current out, writes back v/u and reports spikes.
module izh_neuron_scheduler
  import izh_pkg::*;
#(
  parameter int unsigned N_NEURONS = 16,
  parameter int unsigned IDX_W     = $clog2(N_NEURONS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_start,
  output logic             busy,
  output logic             step_done,
  output logic [15:0]      step_cnt,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [2:0]       cfg_sel,
  input  logic [W-1:0]     cfg_data,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_idx,
  input  logic [W-1:0]     i_data,
  output logic [W-1:0]     nrn_a,
  output logic [W-1:0]     nrn_b,
  output logic [W-1:0]     nrn_c,
  output logic [W-1:0]     nrn_d,
  output logic [W-1:0]     nrn_v,
  output logic [W-1:0]     nrn_u,
  output logic [W-1:0]     nrn_i,
  input  logic [W-1:0]     nrn_v_prime,
  input  logic [W-1:0]     nrn_u_prime,
  input  logic             nrn_fired,
  output logic             spk_valid,
  input  logic             spk_ready,
  output logic [IDX_W-1:0] spk_idx
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [W-1:0]     i_hold_q, i_hold_d;
  logic             clr_en;
  logic [W-1:0]     cur_rd;

  logic [W-1:0] a_q [N_NEURONS];
  logic [W-1:0] b_q [N_NEURONS];
  logic [W-1:0] c_q [N_NEURONS];
  logic [W-1:0] d_q [N_NEURONS];
  logic [W-1:0] v_q [N_NEURONS];
  logic [W-1:0] u_q [N_NEURONS];

  // The accumulator is cleared at the end of ISSUE (where nrn_i is sampled),
  // so an injection arriving in ISSUE or CAPTURE lands on the cleared value.
  izh_current_accum #(
    .N_NEURONS(N_NEURONS),
    .IDX_W    (IDX_W)
  ) u_accum (
    .clk       (clk),
    .rst       (rst),
    .clr_en_i  (clr_en),
    .clr_idx_i (idx_q),
    .add_en_i  (i_we),
    .add_idx_i (i_idx),
    .add_data_i(i_data),
    .rd_idx_i  (idx_q),
    .rd_data_o (cur_rd)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    cnt_d     = cnt_q;
    i_hold_d  = i_hold_q;
    clr_en    = 1'b0;
    spk_valid = 1'b0;
    spk_idx   = '0;
    nrn_a     = '0;
    nrn_b     = '0;
    nrn_c     = '0;
    nrn_d     = '0;
    nrn_v     = '0;
    nrn_u     = '0;
    nrn_i     = '0;
    unique case (state_q)
      S_IDLE: begin
        if (step_start) begin
          state_d = S_ISSUE;
          idx_d   = '0;
          busy_d  = 1'b1;
        end
      end
      S_ISSUE: begin
        nrn_a    = a_q[idx_q];
        nrn_b    = b_q[idx_q];
        nrn_c    = c_q[idx_q];
        nrn_d    = d_q[idx_q];
        nrn_v    = v_q[idx_q];
        nrn_u    = u_q[idx_q];
        nrn_i    = cur_rd;
        i_hold_d = cur_rd;
        clr_en   = 1'b1;
        state_d  = S_CAPTURE;
      end
      S_CAPTURE: begin
        nrn_a   = a_q[idx_q];
        nrn_b   = b_q[idx_q];
        nrn_c   = c_q[idx_q];
        nrn_d   = d_q[idx_q];
        nrn_v   = v_q[idx_q];
        nrn_u   = u_q[idx_q];
        nrn_i   = i_hold_q;
        state_d = nrn_fired ? S_SPIKE : S_NEXT;
      end
      S_SPIKE: begin
        spk_valid = 1'b1;
        spk_idx   = idx_q;
        if (spk_ready) state_d = S_NEXT;
      end
      S_NEXT: begin
        if (idx_q == IDX_W'(N_NEURONS - 1)) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_ISSUE;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        cnt_d   = cnt_q + 16'd1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      i_hold_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
      i_hold_q <= i_hold_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned n = 0; n < N_NEURONS; n++) begin
        a_q[n] <= '0;
        b_q[n] <= '0;
        c_q[n] <= '0;
        d_q[n] <= '0;
        v_q[n] <= V_RESET;
        u_q[n] <= '0;
      end
    end else begin
      if (cfg_we && !busy_q) begin
        case (cfg_sel_e'(cfg_sel))
          CFG_A:   a_q[cfg_idx] <= cfg_data;
          CFG_B:   b_q[cfg_idx] <= cfg_data;
          CFG_C:   c_q[cfg_idx] <= cfg_data;
          CFG_D:   d_q[cfg_idx] <= cfg_data;
          CFG_V:   v_q[cfg_idx] <= cfg_data;
          CFG_U:   u_q[cfg_idx] <= cfg_data;
          default: ;
        endcase
      end
      if (state_q == S_CAPTURE) begin
        v_q[idx_q] <= nrn_v_prime;
        u_q[idx_q] <= nrn_u_prime;
      end
    end
  end

  assign busy      = busy_q;
  assign step_done = done_q;
  assign step_cnt  = cnt_q;

endmodule

// File: tb/tb_izh_neuron_scheduler.sv
// Bench for izh_neuron_scheduler: a registered toy datapath closes the loop,
// and a per-timestep schedule of expected outputs is built from a neuron model.
module tb_izh_neuron_scheduler;

  localparam int          N    = 16;
  localparam logic [16:0] VRST = 17'h1BF00;
  localparam logic [16:0] THR  = 17'h01E00;

  logic        clk = 1'b0;
  logic        rst, step_start, busy, step_done, cfg_we, i_we, nrn_fired, spk_valid, spk_ready;
  logic [15:0] step_cnt;
  logic [3:0]  cfg_idx, i_idx, spk_idx;
  logic [2:0]  cfg_sel;
  logic [16:0] cfg_data, i_data, nrn_a, nrn_b, nrn_c, nrn_d, nrn_v, nrn_u, nrn_i;
  logic [16:0] nrn_v_prime, nrn_u_prime;

  always #5 clk = ~clk;

  izh_neuron_scheduler #(.N_NEURONS(16), .IDX_W(4)) dut (
    .clk(clk), .rst(rst), .step_start(step_start), .busy(busy), .step_done(step_done),
    .step_cnt(step_cnt), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_sel(cfg_sel),
    .cfg_data(cfg_data), .i_we(i_we), .i_idx(i_idx), .i_data(i_data),
    .nrn_a(nrn_a), .nrn_b(nrn_b), .nrn_c(nrn_c), .nrn_d(nrn_d), .nrn_v(nrn_v),
    .nrn_u(nrn_u), .nrn_i(nrn_i), .nrn_v_prime(nrn_v_prime), .nrn_u_prime(nrn_u_prime),
    .nrn_fired(nrn_fired), .spk_valid(spk_valid), .spk_ready(spk_ready), .spk_idx(spk_idx)
  );

  // Toy neuron update: fire above 30.0, otherwise integrate a and b.
  function automatic logic [34:0] dp_fn(input logic [16:0] a, b, c, d, v, u, i);
    logic [16:0] s;
    logic        f;
    s = v + i;
    f = ($signed(s) >= $signed(THR));
    return {f, f ? c : s + a, f ? u + d : u + b};
  endfunction

  logic [34:0] dp_q = '0;
  always @(posedge clk) dp_q <= dp_fn(nrn_a, nrn_b, nrn_c, nrn_d, nrn_v, nrn_u, nrn_i);
  assign nrn_fired   = dp_q[34];
  assign nrn_v_prime = dp_q[33:17];
  assign nrn_u_prime = dp_q[16:0];

  logic [16:0] ma[N], mb[N], mc[N], md[N], mv[N], mu[N], mcur[N];
  logic [15:0] mcnt;

  typedef struct {
    logic        busy, done, spv, ready, start, iwe, cwe;
    logic [3:0]  spi, iidx, cidx;
    logic [2:0]  csel;
    logic [16:0] idat, cdat;
    logic [15:0] cnt;
    logic [118:0] nrn;
    int          nid;
  } ent_t;

  ent_t tl[$];
  int   nchk = 0;
  int   nerr = 0;
  int   cyc  = 0;

  function automatic logic [16:0] msat(input logic [16:0] x, input logic [16:0] y);
    int s;
    s = int'($signed(x)) + int'($signed(y));
    if (s > 65535) s = 65535;
    if (s < -65536) s = -65536;
    return s[16:0];
  endfunction

  function automatic ent_t mk(input logic b);
    ent_t e;
    e.busy = b; e.done = 1'b0; e.spv = 1'b0; e.ready = 1'b1; e.start = 1'b0;
    e.iwe = 1'b0; e.cwe = 1'b0; e.spi = '0; e.iidx = '0; e.cidx = '0; e.csel = '0;
    e.idat = '0; e.cdat = '0; e.cnt = mcnt; e.nrn = '0; e.nid = -1;
    return e;
  endfunction

  task automatic reset_model();
    for (int n = 0; n < N; n++) begin
      ma[n] = '0; mb[n] = '0; mc[n] = '0; md[n] = '0; mu[n] = '0; mcur[n] = '0;
      mv[n] = VRST;
    end
    mcnt = '0;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_out(input ent_t e, input string ph);
    chk({ph, ".busy"}, 128'(busy), 128'(e.busy));
    chk({ph, ".step_done"}, 128'(step_done), 128'(e.done));
    chk({ph, ".step_cnt"}, 128'(step_cnt), 128'(e.cnt));
    chk({ph, ".spk_valid"}, 128'(spk_valid), 128'(e.spv));
    chk({ph, ".spk_idx"}, 128'(spk_idx), 128'(e.spi));
    chk({ph, ".nrn"}, 128'({nrn_a, nrn_b, nrn_c, nrn_d, nrn_v, nrn_u, nrn_i}), 128'(e.nrn));
  endtask

  task automatic drive(input ent_t e);
    step_start = e.start; spk_ready = e.ready;
    i_we = e.iwe; i_idx = e.iidx; i_data = e.idat;
    cfg_we = e.cwe; cfg_idx = e.cidx; cfg_sel = e.csel; cfg_data = e.cdat;
  endtask

  // Appends one cycle; an injection in that cycle counts from the next cycle on.
  task automatic push(input ent_t e, input bit rinj);
    if (rinj && !e.iwe && $urandom_range(0, 3) == 0) begin
      e.iwe = 1'b1; e.iidx = 4'($urandom_range(0, 15));
      e.idat = ($urandom_range(0, 1) == 1) ? 17'($urandom) : 17'($signed(12'($urandom)));
    end
    if (e.iwe) mcur[e.iidx] = msat(mcur[e.iidx], e.idat);
    tl.push_back(e);
  endtask

  task automatic build(input int fstall, input bit rinj, input bit inj7, input bit poke);
    ent_t        e;
    logic [34:0] r;
    logic [16:0] iv;
    int          st;
    tl.delete();
    e = mk(1'b0); e.start = 1'b1; push(e, rinj);
    for (int n = 0; n < N; n++) begin
      iv = mcur[n]; mcur[n] = '0;
      e = mk(1'b1); e.nid = n; e.nrn = {ma[n], mb[n], mc[n], md[n], mv[n], mu[n], iv};
      if (poke && n == 6) begin
        e.start = 1'b1; e.cwe = 1'b1; e.cidx = 4'($urandom_range(0, 15));
        e.csel = 3'($urandom_range(0, 5)); e.cdat = 17'($urandom);
      end
      push(e, rinj);
      e.nid = -1; e.start = 1'b0; e.cwe = 1'b0; e.iwe = 1'b0;
      if (inj7 && n == 7) begin e.iwe = 1'b1; e.iidx = 4'd7; e.idat = 17'h00100; end
      push(e, rinj);
      r = dp_fn(ma[n], mb[n], mc[n], md[n], mv[n], mu[n], iv);
      mv[n] = r[33:17]; mu[n] = r[16:0];
      if (r[34]) begin
        st = (fstall >= 0) ? fstall : int'($urandom_range(0, 3));
        for (int s = 0; s <= st; s++) begin
          e = mk(1'b1); e.spv = 1'b1; e.spi = 4'(n); e.ready = (s == st); push(e, rinj);
        end
      end
      push(mk(1'b1), rinj);
    end
    push(mk(1'b1), rinj);
    mcnt++;
    e = mk(1'b0); e.done = 1'b1; push(e, rinj);
  endtask

  task automatic run(input int abort_at);
    for (int k = 0; k < tl.size(); k++) begin
      cyc = k;
      if (k == abort_at) begin
        rst = 1'b1;
        #1;
        reset_model();
        check_out(mk(1'b0), "abort");
        drive(mk(1'b0));
        return;
      end
      check_out(tl[k], "step");
      drive(tl[k]);
      @(posedge clk); #1;
    end
    drive(mk(1'b0));
  endtask

  task automatic cfg_write(input logic [3:0] idx, input logic [2:0] sel, input logic [16:0] d);
    ent_t e;
    e = mk(1'b0); e.cwe = 1'b1; e.cidx = idx; e.csel = sel; e.cdat = d;
    drive(e); @(posedge clk); #1; drive(mk(1'b0));
    case (sel)
      3'd0: ma[idx] = d;
      3'd1: mb[idx] = d;
      3'd2: mc[idx] = d;
      3'd3: md[idx] = d;
      3'd4: mv[idx] = d;
      3'd5: mu[idx] = d;
      default: ;
    endcase
  endtask

  task automatic inject(input logic [3:0] idx, input logic [16:0] d);
    ent_t e;
    e = mk(1'b0); e.iwe = 1'b1; e.iidx = idx; e.idat = d;
    drive(e); @(posedge clk); #1; drive(mk(1'b0));
    mcur[idx] = msat(mcur[idx], d);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ab;
    reset_model();
    rst = 1'b1;
    drive(mk(1'b0));
    repeat (3) @(posedge clk);
    #1;
    check_out(mk(1'b0), "reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // All-zero parameters: quiet step of exactly 3*N+2 cycles.
    build(-1, 1'b0, 1'b0, 1'b0); run(-1);

    // Neuron 5 fires and the consumer stalls for 10 cycles; sel 6/7 are no-ops.
    cfg_write(4'd5, 3'd4, 17'h02800);
    cfg_write(4'd5, 3'd2, VRST);
    cfg_write(4'd5, 3'd3, 17'h00800);
    cfg_write(4'd2, 3'd6, 17'h12345);
    cfg_write(4'd2, 3'd7, 17'h0ABCD);
    build(10, 1'b0, 1'b0, 1'b0); run(-1);

    // Positive and negative accumulator saturation.
    inject(4'd3, 17'h0FF00); inject(4'd3, 17'h0FF00);
    inject(4'd4, 17'h10000); inject(4'd4, 17'h1FFF0);
    build(-1, 1'b0, 1'b0, 1'b0); run(-1);

    // Injection in neuron 7's CAPTURE carries into the next step, which also
    // receives a step_start and a config write while busy.
    build(-1, 1'b0, 1'b1, 1'b0); run(-1);
    build(-1, 1'b0, 1'b0, 1'b1); run(-1);

    for (int t = 0; t < 6; t++) begin
      repeat (4) cfg_write(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), 17'($urandom));
      if ($urandom_range(0, 1) == 1) inject(4'($urandom_range(0, 15)), 17'($urandom));
      build(-1, 1'b1, 1'b0, 1'b0); run(-1);
    end

    // Reset while neuron 9 is being issued.
    build(-1, 1'b0, 1'b0, 1'b0);
    ab = 0;
    for (int k = 0; k < tl.size(); k++) if (tl[k].nid == 9) ab = k;
    run(ab);
    repeat (2) @(posedge clk);
    #1;
    check_out(mk(1'b0), "in_reset");
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check_out(mk(1'b0), "post_reset");
    end
    build(-1, 1'b0, 1'b0, 1'b0); run(-1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
